// File: rtl/ssp_pkg.sv
// Shared definitions for the parametrised SSP transmitter: FSM state encoding,
// legal parameter ranges and a configuration legality helper.
// No ports; imported by ssp_tx_param and ssp_shifter.
package ssp_pkg;

    typedef logic [1:0] ssp_tx_state_t;

    localparam ssp_tx_state_t SSP_TX_IDLE  = 2'd0;
    localparam ssp_tx_state_t SSP_TX_SHIFT = 2'd1;
    localparam ssp_tx_state_t SSP_TX_GAP   = 2'd2;

    localparam int SSP_DW_MIN  = 4;
    localparam int SSP_DW_MAX  = 16;
    localparam int SSP_GAP_MIN = 0;
    localparam int SSP_GAP_MAX = 15;

    // Gap counter only ever needs to hold GAP_CYCLES-1.
    localparam int SSP_GAP_CW = $clog2(SSP_GAP_MAX + 1);

    function automatic bit ssp_tx_cfg_legal(input int dw, input int gap);
        return (dw >= SSP_DW_MIN) && (dw <= SSP_DW_MAX) &&
               (gap >= SSP_GAP_MIN) && (gap <= SSP_GAP_MAX);
    endfunction

endpackage

// File: rtl/ssp_tx_param_if.sv
// FIFO-side and pad-side signal bundle of the SSP transmitter.
// master: the transmitter (reads FIFO head, drives pop/done/busy and pads).
// slave:  the environment (FIFO + enable source, pad observer).
interface ssp_tx_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_en;
    logic                  tx_empty;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_pop;
    logic                  tx_done;
    logic                  busy;
    logic                  SSPTXD;
    logic                  SSPFSSOUT;
    logic                  SSPOE_B;

    modport master (
        input  tx_en, tx_empty, tx_data,
        output tx_pop, tx_done, busy, SSPTXD, SSPFSSOUT, SSPOE_B
    );

    modport slave (
        output tx_en, tx_empty, tx_data,
        input  tx_pop, tx_done, busy, SSPTXD, SSPFSSOUT, SSPOE_B
    );

endinterface

// File: rtl/ssp_shifter.sv
// Load/shift register feeding the SSP serial line, MSB- or LSB-first.
// Latency: load_bit_o is combinational from data_i; next_bit_o is the bit
// that follows the one currently on the line. No backpressure (driven by FSM).
// Ports: clk_i/rst_i (async active-high), load_i, shift_i, data_i,
//        load_bit_o, next_bit_o, parity_o (only with SSP_TX_PARITY_EN).
// Optional feature macro: SSP_TX_PARITY_EN (even parity of the loaded word).
module ssp_shifter
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  load_bit_o,
    output logic                  next_bit_o
`ifdef SSP_TX_PARITY_EN
    ,
    output logic                  parity_o
`endif
);

    // sh_q holds only the bits not yet placed on the line: the first bit goes
    // straight from data_i into the pad register, so the word is stored
    // pre-shifted by one position on load.
    logic [DATA_WIDTH-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = (LSB_FIRST != 0) ? (data_i >> 1) : (data_i << 1);
        end else if (shift_i) begin
            sh_d = (LSB_FIRST != 0) ? (sh_q >> 1) : (sh_q << 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign load_bit_o = (LSB_FIRST != 0) ? data_i[0] : data_i[DATA_WIDTH-1];
    assign next_bit_o = (LSB_FIRST != 0) ? sh_q[0]   : sh_q[DATA_WIDTH-1];

`ifdef SSP_TX_PARITY_EN
    logic par_q, par_d;

    assign par_d = load_i ? (^data_i) : par_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign parity_o = par_q;
`endif

endmodule

// File: rtl/ssp_tx_param.sv
// Parametrised SSP serial transmitter: pops words from a show-ahead FIFO and
// serialises them with a one-cycle frame pulse, optional inter-frame gap.
// Latency: first bit on SSPTXD one cycle after the accept (tx_pop) edge.
// Backpressure: words are taken only at frame boundaries when tx_en & !tx_empty.
// Ports: SSPCLKOUT (clock), pclear (async active-high reset), bus (master
//        modport: tx_en/tx_empty/tx_data in; tx_pop/tx_done/busy and the
//        registered pads SSPTXD/SSPFSSOUT/SSPOE_B out).
// Optional feature macro: SSP_TX_PARITY_EN (appends an even-parity bit).
module ssp_tx_param
    import ssp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic           SSPCLKOUT,
    input  logic           pclear,
    ssp_tx_param_if.master bus
);

    if (!ssp_tx_cfg_legal(DATA_WIDTH, GAP_CYCLES)) begin : g_bad_cfg
        $error("ssp_tx_param: DATA_WIDTH or GAP_CYCLES out of range");
    end

`ifdef SSP_TX_PARITY_EN
    localparam int FRAME_LEN = DATA_WIDTH + 1;
`else
    localparam int FRAME_LEN = DATA_WIDTH;
`endif
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]         CNT_LOAD = CW'(FRAME_LEN - 1);
    localparam logic [SSP_GAP_CW-1:0] GAP_LOAD =
        SSP_GAP_CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    ssp_tx_state_t         state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SSP_GAP_CW-1:0] gap_q, gap_d;
    logic                  txd_q, txd_d;
    logic                  fss_q, fss_d;
    logic                  oeb_q, oeb_d;

    logic accept;
    logic last_bit;
    logic more_bits;
    logic shift_en;
    logic load_bit;
    logic next_bit;
`ifdef SSP_TX_PARITY_EN
    logic parity_bit;
`endif

    // Counter counts down to 0 on the final cycle of the frame.
    assign last_bit  = (state_q == SSP_TX_SHIFT) && (cnt_q == '0);
    assign more_bits = (state_q == SSP_TX_SHIFT) && (cnt_q != '0);

    // Frame boundaries: idle, or the last bit when frames run back-to-back.
    // Gated by pclear so no pop escapes while reset is held.
    assign accept = !pclear && bus.tx_en && !bus.tx_empty &&
                    ((state_q == SSP_TX_IDLE) || (last_bit && (GAP_CYCLES == 0)));

    assign shift_en = (state_q == SSP_TX_SHIFT) && !accept;

    ssp_shifter #(
        .DATA_WIDTH (DATA_WIDTH),
        .LSB_FIRST  (LSB_FIRST)
    ) u_shifter (
        .clk_i      (SSPCLKOUT),
        .rst_i      (pclear),
        .load_i     (accept),
        .shift_i    (shift_en),
        .data_i     (bus.tx_data),
        .load_bit_o (load_bit),
        .next_bit_o (next_bit)
`ifdef SSP_TX_PARITY_EN
        ,
        .parity_o   (parity_bit)
`endif
    );

    // State register (includes the registered pad outputs).
    always_ff @(posedge SSPCLKOUT or posedge pclear) begin
        if (pclear) begin
            state_q <= SSP_TX_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            txd_q   <= 1'b0;
            fss_q   <= 1'b0;
            oeb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            txd_q   <= txd_d;
            fss_q   <= fss_d;
            oeb_q   <= oeb_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        case (state_q)
            SSP_TX_IDLE: begin
                if (accept) begin
                    state_d = SSP_TX_SHIFT;
                    cnt_d   = CNT_LOAD;
                end
            end
            SSP_TX_SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (GAP_CYCLES > 0) begin
                    state_d = SSP_TX_GAP;
                    gap_d   = GAP_LOAD;
                end else if (accept) begin
                    cnt_d = CNT_LOAD;
                end else begin
                    state_d = SSP_TX_IDLE;
                end
            end
            SSP_TX_GAP: begin
                if (gap_q == '0) begin
                    state_d = SSP_TX_IDLE;
                end else begin
                    gap_d = gap_q - SSP_GAP_CW'(1);
                end
            end
            default: begin
                state_d = SSP_TX_IDLE;
            end
        endcase
    end

    // Output logic: pad registers are loaded with the value for the coming
    // cycle, so an accept drives the new word's first bit and frame pulse.
    always_comb begin
        fss_d = accept;
        oeb_d = !(accept || more_bits);
        txd_d = 1'b0;
        if (accept) begin
            txd_d = load_bit;
        end else if (more_bits) begin
`ifdef SSP_TX_PARITY_EN
            txd_d = (cnt_q == CW'(1)) ? parity_bit : next_bit;
`else
            txd_d = next_bit;
`endif
        end
    end

    assign bus.tx_pop    = accept;
    assign bus.tx_done   = last_bit;
    assign bus.busy      = (state_q != SSP_TX_IDLE);
    assign bus.SSPTXD    = txd_q;
    assign bus.SSPFSSOUT = fss_q;
    assign bus.SSPOE_B   = oeb_q;

endmodule

// File: tb/tb_ssp_tx_param.sv
// Self-checking bench for ssp_tx_param: two instances (8-bit MSB-first no gap,
// 12-bit LSB-first gap 3) fed from bench FIFOs, checked every cycle against a
// frame-offset reference model. Honours SSP_TX_PARITY_EN when defined.
module tb_ssp_tx_param;

    localparam int DW0 = 8;
    localparam int DW1 = 12;
`ifdef SSP_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic pclear;

    always #5 clk = ~clk;

    ssp_tx_param_if #(.DATA_WIDTH(DW0)) if0 ();
    ssp_tx_param_if #(.DATA_WIDTH(DW1)) if1 ();

    ssp_tx_param #(.DATA_WIDTH(DW0), .LSB_FIRST(0), .GAP_CYCLES(0)) dut0 (
        .SSPCLKOUT (clk),
        .pclear    (pclear),
        .bus       (if0.master)
    );

    ssp_tx_param #(.DATA_WIDTH(DW1), .LSB_FIRST(1), .GAP_CYCLES(3)) dut1 (
        .SSPCLKOUT (clk),
        .pclear    (pclear),
        .bus       (if1.master)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Reference model: a frame is FL bit cycles followed by gp idle cycles,
    // tracked as an offset from the accept. Boundaries are "nothing active"
    // or "last bit with no gap".
    int           dw [2] = '{DW0, DW1};
    int           gp [2] = '{0, 3};
    bit           lsb[2] = '{1'b0, 1'b1};
    bit           act[2] = '{1'b0, 1'b0};
    int           tt [2] = '{0, 0};
    logic [15:0]  wd [2];
    logic         en [2];
    int           pops[2] = '{0, 0};
    logic [15:0]  f0[$];
    logic [15:0]  f1[$];

    function automatic logic model_bit(input int d, input int t);
        logic [15:0] w;
        w = wd[d];
        if (t >= dw[d]) return ^w;
        return lsb[d] ? w[t] : w[dw[d]-1-t];
    endfunction

    task automatic step();
        if0.tx_en    = en[0];
        if0.tx_empty = (f0.size() == 0);
        if0.tx_data  = (f0.size() != 0) ? DW0'(f0[0]) : '0;
        if1.tx_en    = en[1];
        if1.tx_empty = (f1.size() == 0);
        if1.tx_data  = (f1.size() != 0) ? DW1'(f1[0]) : '0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int          fl;
            logic        empt, txd, fss, oeb, last, boundary, pop;
            logic [15:0] head;
            logic [5:0]  obs, exp;
            fl   = dw[d] + PAR;
            empt = (d == 0) ? (f0.size() == 0) : (f1.size() == 0);
            head = '0;
            if (!empt) head = (d == 0) ? f0[0] : f1[0];
            if (pclear) act[d] = 1'b0;
            txd = 1'b0; fss = 1'b0; oeb = 1'b1; last = 1'b0;
            if (act[d] && tt[d] < fl) begin
                txd  = model_bit(d, tt[d]);
                fss  = (tt[d] == 0);
                oeb  = 1'b0;
                last = (tt[d] == fl - 1);
            end
            boundary = !act[d] || (gp[d] == 0 && last);
            pop      = boundary && en[d] && !empt && !pclear;
            exp = {pop, last, act[d], txd, fss, oeb};
            if (d == 0)
                obs = {if0.tx_pop, if0.tx_done, if0.busy, if0.SSPTXD, if0.SSPFSSOUT, if0.SSPOE_B};
            else
                obs = {if1.tx_pop, if1.tx_done, if1.busy, if1.SSPTXD, if1.SSPFSSOUT, if1.SSPOE_B};
            chk((d == 0) ? "pop_done_busy_txd_fss_oeb[0]" : "pop_done_busy_txd_fss_oeb[1]",
                32'(obs), 32'(exp));
            if (obs[5]) pops[d]++;
            if (pop) begin
                act[d] = 1'b1;
                tt[d]  = 0;
                wd[d]  = head;
                if (d == 0) void'(f0.pop_front());
                else        void'(f1.pop_front());
            end else if (act[d]) begin
                tt[d]++;
                if (tt[d] == fl + gp[d]) act[d] = 1'b0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, p1;
        bit hit;

        pclear = 1'b1;
        en[0]  = 1'b0;
        en[1]  = 1'b0;
        #1;
        repeat (3) step();
        pclear = 1'b0;

        // Single A5 frame, then a parity-sensitive 07 frame.
        f0.push_back(16'h00A5);
        en[0] = 1'b1;
        repeat (14) step();
        f0.push_back(16'h0007);
        repeat (14) step();

        // Back-to-back on dut0, gapped frames on dut1.
        p0 = pops[0];
        p1 = pops[1];
        f0.push_back(16'h00F0);
        f0.push_back(16'h000F);
        f1.push_back(16'h0001);
        f1.push_back(16'h0800);
        en[1] = 1'b1;
        repeat (50) step();
        chk("b2b_pop_count", 32'(pops[0] - p0), 32'd2);
        chk("gap_pop_count", 32'(pops[1] - p1), 32'd2);

        // Reset during the 4th bit cycle, with the FIFO empty afterwards.
        f0.push_back(16'h003C);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (act[0] && tt[0] == 3) hit = 1'b1;
        end
        chk("rst_mid_frame_reached", 32'(hit), 32'd1);
        pclear = 1'b1;
        repeat (2) step();
        pclear = 1'b0;
        repeat (4) step();
        f0.push_back(16'h0096);
        repeat (12) step();

        // tx_en dropped during bit 2 with words still queued.
        p0 = pops[0];
        f0.push_back(16'h0055);
        f0.push_back(16'h00AA);
        f0.push_back(16'h0081);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            step();
            if (act[0] && tt[0] == 2) hit = 1'b1;
        end
        chk("en_drop_reached", 32'(hit), 32'd1);
        en[0] = 1'b0;
        repeat (15) step();
        chk("en_drop_pop_count", 32'(pops[0] - p0), 32'd1);
        f0.delete();

        // Random traffic with occasional resets.
        repeat (3000) begin
            en[0] = ($urandom_range(0, 9) < 8);
            en[1] = ($urandom_range(0, 9) < 8);
            if (f0.size() < 4 && $urandom_range(0, 1) == 1) f0.push_back(16'($urandom) & 16'h00FF);
            if (f1.size() < 4 && $urandom_range(0, 1) == 1) f1.push_back(16'($urandom) & 16'h0FFF);
            pclear = ($urandom_range(0, 299) == 0);
            step();
        end
        pclear = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
